// File: rtl/md_issue_ctrl_pkg.sv
// md_pkg: shared op codes, MD op encodings and controller state constants for the MD issue path.
package md_pkg;
  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
endpackage

// File: rtl/md_issue_ctrl_sat_counter.sv
// sat_counter: up counter that sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk)
    cnt_q <= rst ? '0 : (inc & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  assign cnt = cnt_q;
endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: EX-stage issue, stall and HI/LO access control for the multiply/divide unit.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [3:0]       ex_md_op,
  input  logic [31:0]      ex_rs,
  input  logic [31:0]      ex_rt,
  input  logic             flush,
  output logic             md_start,
  output logic [1:0]       md_op,
  output logic             md_we,
  output logic             md_hilo,
  output logic [31:0]      md_d1,
  output logic [31:0]      md_d2,
  input  logic             md_busy,
  input  logic [31:0]      md_hi,
  input  logic [31:0]      md_lo,
  output logic             stall,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [1:0] state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic md_start_q, md_we_q, md_hilo_q, err_q;
  logic [1:0] md_op_q;
  logic [31:0] md_d1_q, md_d2_q;
  logic md_instr, accept, is_md, is_mt, is_mf, timeout;
  logic [1:0] op_enc;
  assign md_instr = ex_valid & (ex_md_op != OP_NONE);
  assign stall    = ~rst & md_instr & (state_q == ST_START | (state_q == ST_WAIT & md_busy));
  assign accept   = md_instr & ~stall & ~flush;
  assign is_md    = ex_md_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  assign is_mt    = ex_md_op inside {OP_MTHI, OP_MTLO};
  assign is_mf    = ex_md_op inside {OP_MFHI, OP_MFLO};
  assign op_enc   = ex_md_op == OP_MULT  ? MD_MULT  :
                    ex_md_op == OP_MULTU ? MD_MULTU :
                    ex_md_op == OP_DIV   ? MD_DIV   : MD_DIVU;
  assign timeout  = state_q == ST_WAIT & md_busy & timer_q == TW'(TIMEOUT - 1);
  assign rd_valid = accept & is_mf;
  assign rd_data  = rd_valid ? (ex_md_op == OP_MFHI ? md_hi : md_lo) : '0;
  // A new mult/div may be taken in the same cycle Busy drops, so START wins over IDLE.
  always_comb begin
    state_d = accept & is_md ? ST_START :
              state_q == ST_START ? ST_WAIT :
              state_q == ST_WAIT & (~md_busy | timeout) ? ST_IDLE : state_q;
    timer_d = state_q == ST_WAIT & md_busy & ~timeout ? timer_q + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      err_q      <= 1'b0;
      md_start_q <= 1'b0;
      md_we_q    <= 1'b0;
      md_hilo_q  <= 1'b0;
      md_op_q    <= MD_MULTU;
      md_d1_q    <= '0;
      md_d2_q    <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      err_q      <= err_q | timeout;
      md_start_q <= accept & is_md;
      md_we_q    <= accept & is_mt;
      if (accept & is_md) begin
        md_op_q <= op_enc;
        md_d1_q <= ex_rs;
        md_d2_q <= ex_rt;
      end
      if (accept & is_mt) begin
        md_d1_q   <= ex_rs;
        md_hilo_q <= ex_md_op == OP_MTHI;
      end
    end
  end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall),
    .cnt (stall_cnt)
  );
  assign md_start = md_start_q;
  assign md_we    = md_we_q;
  assign md_hilo  = md_hilo_q;
  assign md_op    = md_op_q;
  assign md_d1    = md_d1_q;
  assign md_d2    = md_d2_q;
  assign err      = err_q;
endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: directed checks of md_issue_ctrl against a small behavioural MD unit.
module tb_md_issue_ctrl;
  import md_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ex_valid = 1'b0;
  logic [3:0] ex_md_op = OP_NONE;
  logic [31:0] ex_rs = '0, ex_rt = '0;
  logic flush = 1'b0;
  logic md_start, md_we, md_hilo, md_busy, stall, rd_valid, err;
  logic [1:0] md_op;
  logic [31:0] md_d1, md_d2, md_hi, md_lo, rd_data, stall_cnt;
  logic hang = 1'b0;
  int cnt_m = 0;
  int total = 0;
  int bad = 0;

  md_issue_ctrl #(.TIMEOUT(15), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_md_op(ex_md_op),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .flush(flush), .md_start(md_start),
    .md_op(md_op), .md_we(md_we), .md_hilo(md_hilo), .md_d1(md_d1),
    .md_d2(md_d2), .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo),
    .stall(stall), .rd_data(rd_data), .rd_valid(rd_valid), .err(err),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // MD model: Busy for 5 (mult) or 10 (div) cycles starting the cycle after Start.
  always @(posedge clk) begin
    if (rst) begin
      md_busy <= 1'b0; cnt_m <= 0; md_hi <= '0; md_lo <= '0;
    end else if (md_start) begin
      md_busy <= 1'b1;
      cnt_m   <= md_op[1] ? 10 : 5;
      case (md_op)
        2'b00: {md_hi, md_lo} <= {32'b0, md_d1} * {32'b0, md_d2};
        2'b01: {md_hi, md_lo} <= $signed({{32{md_d1[31]}}, md_d1}) * $signed({{32{md_d2[31]}}, md_d2});
        2'b10: begin md_lo <= md_d1 / md_d2; md_hi <= md_d1 % md_d2; end
        default: begin md_lo <= $signed(md_d1) / $signed(md_d2); md_hi <= $signed(md_d1) % $signed(md_d2); end
      endcase
    end else begin
      if (cnt_m > 1) cnt_m <= cnt_m - 1;
      else if (!hang) begin md_busy <= 1'b0; cnt_m <= 0; end
      if (md_we) begin
        if (md_hilo) md_hi <= md_d1;
        else md_lo <= md_d1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ex_valid = 1'b0; ex_md_op = OP_NONE; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    ex_valid = v; ex_md_op = op; ex_rs = rs; ex_rt = rt;
    #1;
  endtask

  // Issue op now, then hold a dependent read that must stall n cycles before returning exp_rd.
  task automatic issue_and_read(input string tag, input logic [3:0] op, input logic [31:0] rs,
                                input logic [31:0] rt, input logic [1:0] exp_op,
                                input logic [3:0] rd_op, input int n, input logic [31:0] exp_rd);
    drive(1'b1, op, rs, rt);
    chk({tag, "_issue_nostall"}, {31'b0, stall}, 32'd0);
    tick();
    drive(1'b1, rd_op, '0, '0);
    chk({tag, "_start"}, {31'b0, md_start}, 32'd1);
    chk({tag, "_op"}, {30'b0, md_op}, {30'b0, exp_op});
    chk({tag, "_d1"}, md_d1, rs);
    chk({tag, "_d2"}, md_d2, rt);
    for (int i = 1; i <= n; i++) begin
      chk($sformatf("%s_stall%0d", tag, i), {31'b0, stall}, 32'd1);
      chk($sformatf("%s_rdv%0d", tag, i), {31'b0, rd_valid}, 32'd0);
      if (i == 2) chk({tag, "_start_pulse"}, {31'b0, md_start}, 32'd0);
      tick();
    end
    chk({tag, "_release"}, {31'b0, stall}, 32'd0);
    chk({tag, "_rdv"}, {31'b0, rd_valid}, 32'd1);
    chk({tag, "_rd"}, rd_data, exp_rd);
    tick();
  endtask

  initial begin
    do_reset();
    chk("rst_start", {31'b0, md_start}, 32'd0);
    chk("rst_we", {31'b0, md_we}, 32'd0);
    chk("rst_op", {30'b0, md_op}, 32'd0);
    chk("rst_d1", md_d1, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_cnt", stall_cnt, 32'd0);
    chk("rst_state", {30'b0, dut.state_q}, {30'b0, ST_IDLE});

    issue_and_read("mult", OP_MULT, 32'd7, 32'hFFFF_FFFD, MD_MULT, OP_MFLO, 6, 32'hFFFF_FFEB);
    drive(1'b1, OP_MFHI, '0, '0);
    chk("mult_mfhi", rd_data, 32'hFFFF_FFFF);
    chk("mult_cnt", stall_cnt, 32'd6);
    tick();
    drive(1'b0, OP_NONE, '0, '0);

    do_reset();
    issue_and_read("divu", OP_DIVU, 32'd100, 32'd7, MD_DIVU, OP_MFHI, 11, 32'd2);
    drive(1'b1, OP_MFLO, '0, '0);
    chk("divu_mflo", rd_data, 32'd14);
    chk("divu_cnt", stall_cnt, 32'd11);
    tick();

    do_reset();
    drive(1'b1, OP_MTHI, 32'h1234, '0);
    chk("mthi_nostall", {31'b0, stall}, 32'd0);
    tick();
    drive(1'b0, OP_NONE, '0, '0);
    chk("mthi_we", {31'b0, md_we}, 32'd1);
    chk("mthi_hilo", {31'b0, md_hilo}, 32'd1);
    chk("mthi_d1", md_d1, 32'h1234);
    chk("mthi_start", {31'b0, md_start}, 32'd0);
    tick();
    chk("mthi_we_pulse", {31'b0, md_we}, 32'd0);
    tick();
    drive(1'b1, OP_MFHI, '0, '0);
    chk("mthi_mfhi", rd_data, 32'h1234);
    chk("mthi_cnt", stall_cnt, 32'd0);
    tick();
    drive(1'b1, OP_MTLO, 32'h55AA, '0);
    tick();
    drive(1'b0, OP_NONE, '0, '0);
    chk("mtlo_hilo", {31'b0, md_hilo}, 32'd0);
    chk("mtlo_we", {31'b0, md_we}, 32'd1);

    do_reset();
    flush = 1'b1;
    drive(1'b1, OP_MULT, 32'd3, 32'd4);
    chk("flush_rdv", {31'b0, rd_valid}, 32'd0);
    tick();
    flush = 1'b0;
    drive(1'b1, OP_MFLO, '0, '0);
    chk("flush_start", {31'b0, md_start}, 32'd0);
    chk("flush_state", {30'b0, dut.state_q}, {30'b0, ST_IDLE});
    chk("flush_nostall", {31'b0, stall}, 32'd0);
    chk("flush_mflo", {31'b0, rd_valid}, 32'd1);
    tick();
    drive(1'b0, OP_NONE, '0, '0);

    do_reset();
    drive(1'b1, OP_DIV, 32'd20, 32'd3);
    tick();
    drive(1'b0, OP_NONE, '0, '0);
    tick(); tick();
    drive(1'b1, OP_MFLO, '0, '0);
    chk("rstw_stall", {31'b0, stall}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rstw_state", {30'b0, dut.state_q}, {30'b0, ST_IDLE});
    chk("rstw_nostall", {31'b0, stall}, 32'd0);
    chk("rstw_cnt", stall_cnt, 32'd0);
    chk("rstw_err", {31'b0, err}, 32'd0);
    issue_and_read("rstw_mult", OP_MULT, 32'd3, 32'd5, MD_MULT, OP_MFLO, 6, 32'd15);
    drive(1'b0, OP_NONE, '0, '0);

    do_reset();
    hang = 1'b1;
    drive(1'b1, OP_MULT, 32'd2, 32'd2);
    tick();
    drive(1'b0, OP_NONE, '0, '0);
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("hang_noerr%0d", c), {31'b0, err}, 32'd0);
      tick();
    end
    chk("hang_err", {31'b0, err}, 32'd1);
    chk("hang_idle", {30'b0, dut.state_q}, {30'b0, ST_IDLE});
    drive(1'b1, OP_MFHI, '0, '0);
    chk("hang_nostall", {31'b0, stall}, 32'd0);
    tick(); tick(); tick();
    chk("hang_sticky", {31'b0, err}, 32'd1);
    hang = 1'b0;
    do_reset();
    chk("hang_clr", {31'b0, err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Pipeline-side controller for the multiply/divide unit, sitting in the EX stage between instruction decode and the MD unit. It accepts decoded HI/LO-class instructions (mult/multu/div/divu/mfhi/mflo/mthi/mtlo) and converts them into registered Start/WE pulses toward the unit. It tracks the issue-to-Busy gap and raises a pipeline stall while any HI/LO instruction would conflict. It also returns mfhi/mflo data, counts stall cycles and flags a hung unit.

## Interface
- TIMEOUT, 15, max WAIT cycles with md_busy high before err is raised
- CNT_W, 32, width of stall_cnt
---
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  EX instruction valid
- ex_md_op  in  4  md_pkg code: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO
- ex_rs, ex_rt  in  32  operand values (already forwarded)
- flush  in  1  cancel the EX instruction this cycle
- md_start  out  1  one-cycle Start pulse to MD
- md_op  out  2  00 multu, 01 mult, 10 divu, 11 div
- md_we  out  1  one-cycle HI/LO write pulse
- md_hilo  out  1  1 = Hi, 0 = Lo (for md_we)
- md_d1, md_d2  out  32  registered operands (md_d1 = rs, md_d2 = rt)
- md_busy  in  1  MD busy
- md_hi, md_lo  in  32  MD result registers
- stall  out  1  hold IF/ID/EX (combinational)
- rd_data  out  32  mfhi/mflo result (combinational)
- rd_valid  out  1  rd_data valid this cycle
- err  out  1  sticky timeout flag
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- States: IDLE, START, WAIT.
- Define md_instr = ex_valid & ex_md_op != NONE. Define accept = md_instr & !stall & !flush.
- stall = md_instr & (state == START | (state == WAIT & md_busy)). Non-HI/LO instructions never stall and may overlap a running operation.
- accept of MULT/MULTU/DIV/DIVU: register md_d1/md_d2/md_op; md_start=1 next cycle; state→START.
- START: md_start high for this cycle only; →WAIT unconditionally.
- WAIT: md_busy=1 → stay, timer++. md_busy=0 → IDLE. Timer reaching TIMEOUT → err=1, IDLE.
- In WAIT with md_busy=0, stall is 0, so a waiting HI/LO instruction is accepted that cycle.
- accept of MFHI/MFLO: rd_data = md_hi / md_lo, rd_valid=1 in the same cycle; no state change.
- accept of MTHI/MTLO: next cycle md_we=1, md_hilo=1/0, md_d1=ex_rs; no state change, no stall.
- flush in the acceptance cycle suppresses all effects. flush after acceptance does not abort an issued operation, and the controller still waits for Busy to fall.
- stall_cnt increments every cycle stall=1 and saturates at all-ones.
- err clears only on rst.
- rst: state IDLE, md_start/md_we/md_hilo/rd_valid/stall/err = 0, md_op=00, md_d1/md_d2=0, stall_cnt=0, timer=0.
- rst asserted mid-operation abandons the operation; MD shares the same rst.

## Timing
- Issue latency: accept at cycle N, md_start in N+1. MD samples Start at the N+1/N+2 edge; md_busy is visible from N+2.
- The START state covers the N+1 gap, when Busy is not yet visible.
- Mult: md_busy high N+2..N+6. The earliest dependent mf*/mt*/mult/div is accepted at N+7.
- Div: md_busy high N+2..N+11. The earliest dependent instruction is accepted at N+12.
- mfhi/mflo: zero-cycle read when not stalled.
- mthi/mtlo: write pulse one cycle after accept; the unit updates at the following edge.
- A mf* accepted the cycle after mt* sees the old value. This is a decode-side hazard and is handled upstream by a one-cycle interlock, not here.

## Structure
- md_pkg holds:
  - the ex_md_op codes
  - the MD Op encodings (MD_MULTU=00, MD_MULT=01, MD_DIVU=10, MD_DIV=11)
  - the state enum
- One natural sub-module: sat_counter (parameterised width, inc, rst), instanced for stall_cnt. The TIMEOUT timer is a plain local counter.

## Test plan
- MULT rs=7, rt=0xFFFFFFFD accepted at cycle 0, then MFLO from cycle 1:
  - md_start=1, md_op=01 at cycle 1.
  - stall at cycles 1..6.
  - MFLO accepted at cycle 7 with rd_data=0xFFFFFFEB; MFHI next returns 0xFFFFFFFF.
  - stall_cnt=6.
- DIVU 100/7 followed by MFHI:
  - stall at cycles 1..11.
  - MFHI accepted at cycle 12, rd_data=2; MFLO returns 14.
  - stall_cnt=11.
- MTHI rs=0x1234 at cycle 0:
  - cycle 1: md_we=1, md_hilo=1, md_d1=0x1234, no stall.
  - MFHI at cycle 3 returns 0x1234.
- MULT with flush=1 in its acceptance cycle: md_start stays 0, state IDLE, and a following MFLO is accepted without stall.
- rst asserted during WAIT of a DIV: next cycle state IDLE, stall=0, stall_cnt=0, err=0, and a new MULT issues normally.
- Bench MD model holds md_busy high indefinitely after a MULT: err=1 after 15 WAIT cycles, state returns to IDLE, and err stays high until rst.
